// File: rtl/cpu_dmem_slave_pkg.sv
// Shared state codes, byte-lane encodings and decode helpers for the data-memory slave.
package cpu_dmem_slave_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_ACK  = 2'd2
  } dmem_state_e;

  localparam logic [1:0] DMEM_SEL_HI = 2'b10;
  localparam logic [1:0] DMEM_SEL_LO = 2'b01;
  localparam logic [1:0] DMEM_SEL_HW = 2'b11;

  function automatic logic misaligned_hw(input logic adr0, input logic [1:0] sel);
    return adr0 && (sel == DMEM_SEL_HW);
  endfunction

endpackage

// File: rtl/cpu_dmem_slave_ram.sv
// Single-port 2^AW x 16 data RAM: big-endian byte write enables, registered read that
// reads as zero in every cycle following a cycle without a read request.
module cpu_dmem_ram #(
  parameter int AW = 12
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic [AW-1:0] addr,
  input  logic [15:0]   wdata,
  input  logic [1:0]    be,
  input  logic          we,
  input  logic          re,
  output logic [15:0]   rdata
);

  logic [15:0] mem_r [0:(1<<AW)-1];
  logic [15:0] q_r;

  // byte-lane write; be[1] is the even (high) byte
  always_ff @(posedge clk_i) begin
    if (we && be[1]) mem_r[addr][15:8] <= wdata[15:8];
    if (we && be[0]) mem_r[addr][7:0]  <= wdata[7:0];
  end

  // read register doubles as the bus data output, so it drops to zero between reads
  always_ff @(posedge clk_i) begin
    if (rst_i)   q_r <= 16'h0000;
    else if (re) q_r <= mem_r[addr];
    else         q_r <= 16'h0000;
  end

  assign rdata = q_r;

endmodule

// File: rtl/cpu_dmem_slave.sv
// Wishbone-classic slave for the 16-bit data memory bus with fixed wait states.
// Optional DMEM_ERR_EN: out-of-window or misaligned halfword accesses end with wb_err_o.
module cpu_dmem_slave
  import cpu_dmem_slave_pkg::*;
#(
  parameter int          AW          = 12,
  parameter int          WAIT_STATES = 1,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [31:0] wb_adr_i,
  input  logic [15:0] wb_dat_i,
  output logic [15:0] wb_dat_o,
  input  logic [1:0]  wb_sel_i,
  input  logic        wb_we_i,
  input  logic        wb_stb_i,
  input  logic        wb_cyc_i,
  output logic        wb_ack_o,
  output logic        wb_err_o
);

  localparam logic [3:0] WS_LAST   = 4'(WAIT_STATES - 1);
  localparam logic       ZERO_WAIT = (WAIT_STATES == 0);

  dmem_state_e   state_r;
  logic [3:0]    cnt_r;
  logic [AW-1:0] idx_r;
  logic [15:0]   dat_r;
  logic [1:0]    sel_r;
  logic          we_r, err_r, ack_r, err_o_r;

  logic [31:0]   off_s;
  logic [AW-1:0] idx_s, ram_addr_s;
  logic          req_s, err_in_s, go_ack_s, go_we_s, go_err_s, rd_en_s, wr_en_s;
  logic          dmem_unused_s;

  assign off_s = wb_adr_i - BASE_ADDR;
  assign idx_s = off_s[AW:1];
  assign req_s = wb_cyc_i & wb_stb_i;
  assign dmem_unused_s = &{1'b0, off_s[31:AW+1], off_s[0]};

`ifdef DMEM_ERR_EN
  assign err_in_s = (|(off_s >> (AW + 1))) | misaligned_hw(wb_adr_i[0], wb_sel_i);
`else
  assign err_in_s = 1'b0;
`endif

  // decide whether the coming edge enters ACK, and with which request attributes
  always_comb begin
    go_ack_s = 1'b0;
    go_we_s  = we_r;
    go_err_s = err_r;
    case (state_r)
      ST_IDLE: begin
        go_ack_s = req_s && ZERO_WAIT;
        go_we_s  = wb_we_i;
        go_err_s = err_in_s;
      end
      ST_WAIT: go_ack_s = wb_cyc_i && (cnt_r == WS_LAST);
      ST_ACK:  go_ack_s = 1'b0;
      default: go_ack_s = 1'b0;
    endcase
  end

  // the read is issued on the edge entering ACK; idle cycles address the RAM straight from the bus
  assign rd_en_s    = go_ack_s & ~go_we_s & ~go_err_s;
  assign wr_en_s    = (state_r == ST_ACK) & we_r & ~err_r & ~rst_i;
  assign ram_addr_s = (state_r == ST_IDLE) ? idx_s : idx_r;

  // transfer FSM with registered ack/err
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_r <= ST_IDLE;
      cnt_r   <= 4'd0;
      ack_r   <= 1'b0;
      err_o_r <= 1'b0;
      idx_r   <= '0;
      dat_r   <= 16'h0000;
      sel_r   <= 2'b00;
      we_r    <= 1'b0;
      err_r   <= 1'b0;
    end else begin
      ack_r   <= go_ack_s & ~go_err_s;
      err_o_r <= go_ack_s & go_err_s;
      case (state_r)
        ST_IDLE: begin
          if (req_s) begin
            idx_r   <= idx_s;
            dat_r   <= wb_dat_i;
            sel_r   <= wb_sel_i;
            we_r    <= wb_we_i;
            err_r   <= err_in_s;
            cnt_r   <= 4'd0;
            state_r <= ZERO_WAIT ? ST_ACK : ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (!wb_cyc_i)              state_r <= ST_IDLE;
          else if (cnt_r == WS_LAST)  state_r <= ST_ACK;
          else                        cnt_r   <= cnt_r + 4'd1;
        end
        ST_ACK:  state_r <= ST_IDLE;
        default: state_r <= ST_IDLE;
      endcase
    end
  end

  cpu_dmem_ram #(.AW(AW)) u_ram (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .addr  (ram_addr_s),
    .wdata (dat_r),
    .be    (sel_r),
    .we    (wr_en_s),
    .re    (rd_en_s),
    .rdata (wb_dat_o)
  );

  assign wb_ack_o = ack_r;
  assign wb_err_o = err_o_r;

endmodule

// File: tb/tb_cpu_dmem_slave.sv
// Directed bench for cpu_dmem_slave: three instances (WS=1, WS=0, WS=3/AW=4) on a shared bus.
module tb_cpu_dmem_slave;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] adr;
  logic [15:0] dat_w;
  logic [1:0]  sel;
  logic        we, stb;
  logic [2:0]  cyc_v, ack_v, err_v;
  logic [15:0] rd0, rd1, rd2;

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  cpu_dmem_slave #(.AW(12), .WAIT_STATES(1), .BASE_ADDR(32'h0)) u0 (
    .clk_i(clk), .rst_i(rst), .wb_adr_i(adr), .wb_dat_i(dat_w), .wb_dat_o(rd0),
    .wb_sel_i(sel), .wb_we_i(we), .wb_stb_i(stb), .wb_cyc_i(cyc_v[0]),
    .wb_ack_o(ack_v[0]), .wb_err_o(err_v[0]));

  cpu_dmem_slave #(.AW(12), .WAIT_STATES(0), .BASE_ADDR(32'h0)) u1 (
    .clk_i(clk), .rst_i(rst), .wb_adr_i(adr), .wb_dat_i(dat_w), .wb_dat_o(rd1),
    .wb_sel_i(sel), .wb_we_i(we), .wb_stb_i(stb), .wb_cyc_i(cyc_v[1]),
    .wb_ack_o(ack_v[1]), .wb_err_o(err_v[1]));

  cpu_dmem_slave #(.AW(4), .WAIT_STATES(3), .BASE_ADDR(32'h0)) u2 (
    .clk_i(clk), .rst_i(rst), .wb_adr_i(adr), .wb_dat_i(dat_w), .wb_dat_o(rd2),
    .wb_sel_i(sel), .wb_we_i(we), .wb_stb_i(stb), .wb_cyc_i(cyc_v[2]),
    .wb_ack_o(ack_v[2]), .wb_err_o(err_v[2]));

  typedef struct {
    int          d;
    logic        w;
    logic [31:0] a;
    logic [15:0] dw;
    logic [1:0]  s;
    int          lat;
    logic [15:0] rd;
    logic        e;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input int d, input logic w, input logic [31:0] a,
                              input logic [15:0] dw, input logic [1:0] s, input int lat,
                              input logic [15:0] rd, input logic e);
    vec_t v;
    v.d = d; v.w = w; v.a = a; v.dw = dw; v.s = s; v.lat = lat; v.rd = rd; v.e = e;
    return v;
  endfunction

  function automatic logic [15:0] rd_sel(input int d);
    case (d)
      0:       return rd0;
      1:       return rd1;
      default: return rd2;
    endcase
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // one transfer starting just after a posedge; lat counts cycles from request to ack/err
  task automatic xfer(input int d, input logic w, input logic [31:0] a, input logic [15:0] dw,
                      input logic [1:0] s, output int lat, output logic [15:0] rdat,
                      output logic e);
    lat = -1; rdat = 16'h0; e = 1'b0;
    adr = a; dat_w = dw; sel = s; we = w; stb = 1'b1; cyc_v[d] = 1'b1;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (ack_v[d] || err_v[d]) begin
        lat = k; rdat = rd_sel(d); e = err_v[d];
        break;
      end
    end
    @(posedge clk); #1;
    stb = 1'b0; cyc_v[d] = 1'b0; we = 1'b0;
  endtask

  task automatic idle_no_ack(input string name, input int d, input int cycles);
    logic seen;
    seen = 1'b0;
    for (int k = 0; k < cycles; k++) begin
      @(negedge clk);
      if (ack_v[d] || err_v[d]) seen = 1'b1;
    end
    check(name, {31'd0, seen}, 32'd0);
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int          lat;
    logic [15:0] rdat;
    logic        e;
    int          n;
    logic [7:0]  mask;
    logic [15:0] exp3 [3];

    rst = 1'b1; adr = 32'h0; dat_w = 16'h0; sel = 2'b00; we = 1'b0; stb = 1'b0; cyc_v = 3'b000;

    vecs.push_back(mk(0, 1'b1, 32'h10, 16'hBEEF, 2'b11, 2, 16'h0000, 1'b0));
    vecs.push_back(mk(0, 1'b0, 32'h10, 16'h0000, 2'b11, 2, 16'hBEEF, 1'b0));
    vecs.push_back(mk(0, 1'b1, 32'h20, 16'h1234, 2'b11, 2, 16'h0000, 1'b0));
    vecs.push_back(mk(0, 1'b1, 32'h21, 16'h00AB, 2'b01, 2, 16'h0000, 1'b0));
    vecs.push_back(mk(0, 1'b1, 32'h20, 16'hCD00, 2'b10, 2, 16'h0000, 1'b0));
    vecs.push_back(mk(0, 1'b0, 32'h20, 16'h0000, 2'b11, 2, 16'hCDAB, 1'b0));
    vecs.push_back(mk(0, 1'b1, 32'h10, 16'hFFFF, 2'b00, 2, 16'h0000, 1'b0));
    vecs.push_back(mk(0, 1'b0, 32'h10, 16'h0000, 2'b11, 2, 16'hBEEF, 1'b0));
    vecs.push_back(mk(0, 1'b1, 32'h30, 16'hA5A5, 2'b11, 2, 16'h0000, 1'b0));
    vecs.push_back(mk(0, 1'b0, 32'h31, 16'h0000, 2'b01, 2, 16'hA5A5, 1'b0));
    vecs.push_back(mk(1, 1'b1, 32'h50, 16'h1111, 2'b11, 1, 16'h0000, 1'b0));
    vecs.push_back(mk(1, 1'b1, 32'h52, 16'h2222, 2'b11, 1, 16'h0000, 1'b0));
    vecs.push_back(mk(1, 1'b1, 32'h54, 16'h3333, 2'b11, 1, 16'h0000, 1'b0));
    vecs.push_back(mk(2, 1'b1, 32'h02, 16'h1111, 2'b11, 4, 16'h0000, 1'b0));
    vecs.push_back(mk(2, 1'b1, 32'h00, 16'h7777, 2'b11, 4, 16'h0000, 1'b0));
`ifdef DMEM_ERR_EN
    vecs.push_back(mk(2, 1'b0, 32'h40, 16'h0000, 2'b11, 4, 16'h0000, 1'b1));
    vecs.push_back(mk(2, 1'b1, 32'h03, 16'h9999, 2'b11, 4, 16'h0000, 1'b1));
    vecs.push_back(mk(2, 1'b0, 32'h02, 16'h0000, 2'b11, 4, 16'h1111, 1'b0));
`else
    vecs.push_back(mk(2, 1'b0, 32'h40, 16'h0000, 2'b11, 4, 16'h7777, 1'b0));
    vecs.push_back(mk(2, 1'b1, 32'h03, 16'h9999, 2'b11, 4, 16'h0000, 1'b0));
    vecs.push_back(mk(2, 1'b0, 32'h02, 16'h0000, 2'b11, 4, 16'h9999, 1'b0));
`endif

    // reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset_ack_err", {26'd0, ack_v, err_v}, 32'd0);
    check("reset_dat", {16'd0, rd0 | rd1 | rd2}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    foreach (vecs[i]) begin
      xfer(vecs[i].d, vecs[i].w, vecs[i].a, vecs[i].dw, vecs[i].s, lat, rdat, e);
      check($sformatf("vec%0d_lat", i), 32'(lat), 32'(vecs[i].lat));
      check($sformatf("vec%0d_err", i), {31'd0, e}, {31'd0, vecs[i].e});
      if (!vecs[i].w || vecs[i].e)
        check($sformatf("vec%0d_rdata", i), {16'd0, rdat}, {16'd0, vecs[i].rd});
    end

    // back-to-back reads with stb held high, zero wait states
    exp3[0] = 16'h1111; exp3[1] = 16'h2222; exp3[2] = 16'h3333;
    n = 0; mask = 8'h00;
    adr = 32'h50; we = 1'b0; sel = 2'b11; stb = 1'b1; cyc_v[1] = 1'b1;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (ack_v[1]) begin
        mask[k] = 1'b1;
        if (n < 3) check($sformatf("b2b_data%0d", n), {16'd0, rd1}, {16'd0, exp3[n]});
        n++;
        if (n < 3) adr = 32'h50 + 32'(2 * n);
        else begin
          stb = 1'b0; cyc_v[1] = 1'b0;
        end
      end
    end
    check("b2b_ack_count", 32'(n), 32'd3);
    check("b2b_ack_cycles", {24'd0, mask}, 32'h0000_002A);
    @(posedge clk); #1;

    // aborted read after one WAIT cycle
    adr = 32'h00; we = 1'b0; sel = 2'b11; stb = 1'b1; cyc_v[2] = 1'b1;
    @(posedge clk); #1;
    stb = 1'b0; cyc_v[2] = 1'b0;
    idle_no_ack("abort_rd_noack", 2, 8);

    // aborted write after two WAIT cycles must leave RAM unchanged
    adr = 32'h00; dat_w = 16'hDEAD; we = 1'b1; sel = 2'b11; stb = 1'b1; cyc_v[2] = 1'b1;
    repeat (2) begin @(posedge clk); #1; end
    stb = 1'b0; cyc_v[2] = 1'b0; we = 1'b0;
    idle_no_ack("abort_wr_noack", 2, 8);
    xfer(2, 1'b0, 32'h00, 16'h0000, 2'b11, lat, rdat, e);
    check("abort_wr_ram_kept", {16'd0, rdat}, 32'h0000_7777);
    xfer(2, 1'b1, 32'h04, 16'h4444, 2'b11, lat, rdat, e);
    check("post_abort_wr_lat", 32'(lat), 32'd4);
    xfer(2, 1'b0, 32'h04, 16'h0000, 2'b11, lat, rdat, e);
    check("post_abort_rd", {16'd0, rdat}, 32'h0000_4444);

    // reset during WAIT of a write
    adr = 32'h30; dat_w = 16'h5555; we = 1'b1; sel = 2'b11; stb = 1'b1; cyc_v[0] = 1'b1;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    stb = 1'b0; cyc_v[0] = 1'b0; we = 1'b0;
    @(negedge clk);
    check("rst_cycle_ack_err", {26'd0, ack_v, err_v}, 32'd0);
    check("rst_cycle_dat", {16'd0, rd0}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    idle_no_ack("rst_noack", 0, 6);
    xfer(0, 1'b0, 32'h30, 16'h0000, 2'b11, lat, rdat, e);
    check("rst_write_dropped", {16'd0, rdat}, 32'h0000_A5A5);
    check("rst_after_lat", 32'(lat), 32'd2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
